// File: rtl/glitch_sequencer.sv
// glitch_sequencer: schedules clock-glitch enable windows relative to the
// rising edge of a DUT GPIO trigger. After the trigger edge it waits the
// programmed offset, then issues a train of pulses of programmed width,
// count and spacing. The latched phase select goes to the external delay-line stage.
module glitch_sequencer #(
  parameter int CNT_W = 16,
  parameter int WID_W = 4,
  parameter int REP_W = 4,
  parameter int PH_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_offset,
  input  logic [WID_W-1:0] cfg_width,
  input  logic [REP_W-1:0] cfg_repeat,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [PH_W-1:0]  cfg_phase,
  input  logic             arm,
  input  logic             abort,
  input  logic             trigger,
  output logic             glitch_en,
  output logic [PH_W-1:0]  glitch_phase,
  output logic             busy,
  output logic             done,
  output logic             missed,
  output logic [REP_W-1:0] pulse_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_OFFSET,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             trg_q;
  logic [CNT_W-1:0] off_q, off_d;
  logic [WID_W-1:0] wid_q, wid_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [REP_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             glitch_en_q, glitch_en_d;
  logic             done_q, done_d;
  logic             missed_q, missed_d;
  logic             cfg_ready_q, busy_q;

  logic [CNT_W-1:0] cfg_offset_q;
  logic [WID_W-1:0] cfg_width_q;
  logic [REP_W-1:0] cfg_repeat_q;
  logic [CNT_W-1:0] cfg_gap_q;
  logic [PH_W-1:0]  cfg_phase_q;

  logic             cfg_we;
  logic             rise;
  logic             last_pulse;
  logic [WID_W-1:0] eff_width;
  logic [REP_W-1:0] eff_repeat;
  logic [CNT_W-1:0] eff_gap;
  logic [CNT_W-1:0] cycle_inc;

  // A zero field means "one", so every counter below has a reachable target.
  assign eff_width  = (cfg_width_q  == '0) ? WID_W'(1) : cfg_width_q;
  assign eff_repeat = (cfg_repeat_q == '0) ? REP_W'(1) : cfg_repeat_q;
  assign eff_gap    = (cfg_gap_q    == '0) ? CNT_W'(1) : cfg_gap_q;

  assign cfg_we     = cfg_valid & cfg_ready_q;
  assign rise       = trigger & ~trg_q;
  assign last_pulse = (pulse_cnt_q >= (eff_repeat - REP_W'(1)));
  assign cycle_inc  = (cycle_cnt_q == '1) ? cycle_cnt_q : (cycle_cnt_q + CNT_W'(1));

  // Next-state logic. The offset counter starts at 0 on the trigger edge so the
  // PULSE state (and glitch_en with it) begins exactly offset+1 edges later.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    wid_d       = wid_q;
    gap_d       = gap_q;
    pulse_cnt_d = pulse_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    glitch_en_d = glitch_en_q;
    done_d      = done_q;
    missed_d    = missed_q;
    if (abort) begin
      state_d     = S_IDLE;
      glitch_en_d = 1'b0;
      done_d      = 1'b0;
      missed_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_d     = S_ARMED;
            done_d      = 1'b0;
            missed_d    = 1'b0;
            pulse_cnt_d = '0;
            cycle_cnt_d = '0;
          end
        end
        S_ARMED: begin
          if (rise) begin
            state_d     = S_OFFSET;
            cycle_cnt_d = '0;
            off_d       = '0;
          end
        end
        S_OFFSET: begin
          cycle_cnt_d = cycle_inc;
          if (!trigger) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            missed_d = 1'b1;
          end else if (off_q == cfg_offset_q) begin
            state_d     = S_PULSE;
            wid_d       = WID_W'(1);
            glitch_en_d = 1'b1;
          end else begin
            off_d = off_q + CNT_W'(1);
          end
        end
        S_PULSE: begin
          cycle_cnt_d = cycle_inc;
          if (wid_q == eff_width) begin
            // Final high cycle ends at this edge: the pulse counts as complete.
            pulse_cnt_d = pulse_cnt_q + REP_W'(1);
            glitch_en_d = 1'b0;
            if (last_pulse) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else if (!trigger) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              missed_d = 1'b1;
            end else begin
              state_d = S_GAP;
              gap_d   = CNT_W'(1);
            end
          end else if (!trigger) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            missed_d    = 1'b1;
            glitch_en_d = 1'b0;
          end else begin
            wid_d = wid_q + WID_W'(1);
          end
        end
        S_GAP: begin
          cycle_cnt_d = cycle_inc;
          if (!trigger) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            missed_d = 1'b1;
          end else if (gap_q == eff_gap) begin
            state_d     = S_PULSE;
            wid_d       = WID_W'(1);
            glitch_en_d = 1'b1;
          end else begin
            gap_d = gap_q + CNT_W'(1);
          end
        end
        default: begin
          state_d     = S_IDLE;
          glitch_en_d = 1'b0;
        end
      endcase
    end
  end

  // State, counters, registered status outputs and config latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      trg_q        <= 1'b1;
      off_q        <= '0;
      wid_q        <= '0;
      gap_q        <= '0;
      pulse_cnt_q  <= '0;
      cycle_cnt_q  <= '0;
      glitch_en_q  <= 1'b0;
      done_q       <= 1'b0;
      missed_q     <= 1'b0;
      cfg_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      cfg_offset_q <= '0;
      cfg_width_q  <= '0;
      cfg_repeat_q <= '0;
      cfg_gap_q    <= '0;
      cfg_phase_q  <= '0;
    end else begin
      state_q     <= state_d;
      trg_q       <= trigger;
      off_q       <= off_d;
      wid_q       <= wid_d;
      gap_q       <= gap_d;
      pulse_cnt_q <= pulse_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      glitch_en_q <= glitch_en_d;
      done_q      <= done_d;
      missed_q    <= missed_d;
      cfg_ready_q <= (state_d == S_IDLE) || (state_d == S_DONE);
      busy_q      <= (state_d == S_ARMED) || (state_d == S_OFFSET) ||
                     (state_d == S_PULSE) || (state_d == S_GAP);
      if (cfg_we) begin
        cfg_offset_q <= cfg_offset;
        cfg_width_q  <= cfg_width;
        cfg_repeat_q <= cfg_repeat;
        cfg_gap_q    <= cfg_gap;
        cfg_phase_q  <= cfg_phase;
      end
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign missed       = missed_q;
  assign glitch_en    = glitch_en_q;
  assign glitch_phase = cfg_phase_q;
  assign pulse_cnt    = pulse_cnt_q;
  assign cycle_cnt    = cycle_cnt_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed testbench for glitch_sequencer: one task per scenario, each with
// hand-computed expectations. Edge numbers are counted from the trigger
// detection edge E (edge k means the k-th clock edge after E).
module tb_glitch_sequencer;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_offset;
  logic [3:0]  cfg_width;
  logic [3:0]  cfg_repeat;
  logic [15:0] cfg_gap;
  logic [2:0]  cfg_phase;
  logic        arm;
  logic        abort;
  logic        trigger;
  logic        glitch_en;
  logic [2:0]  glitch_phase;
  logic        busy;
  logic        done;
  logic        missed;
  logic [3:0]  pulse_cnt;
  logic [15:0] cycle_cnt;

  int checks;
  int failures;

  glitch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_offset   (cfg_offset),
    .cfg_width    (cfg_width),
    .cfg_repeat   (cfg_repeat),
    .cfg_gap      (cfg_gap),
    .cfg_phase    (cfg_phase),
    .arm          (arm),
    .abort        (abort),
    .trigger      (trigger),
    .glitch_en    (glitch_en),
    .glitch_phase (glitch_phase),
    .busy         (busy),
    .done         (done),
    .missed       (missed),
    .pulse_cnt    (pulse_cnt),
    .cycle_cnt    (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs set afterwards are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [15:0] off, input logic [3:0] wid,
                           input logic [3:0] rep, input logic [15:0] gp,
                           input logic [2:0] ph);
    cfg_valid  = 1'b1;
    cfg_offset = off;
    cfg_width  = wid;
    cfg_repeat = rep;
    cfg_gap    = gp;
    cfg_phase  = ph;
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Observe n edges after E, recording which ones had glitch_en high.
  task automatic watch(input int n, output logic [63:0] mask, output int first,
                       output logic [15:0] cyc_first, output logic [2:0] ph_first);
    mask      = '0;
    first     = 0;
    cyc_first = '0;
    ph_first  = '0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (glitch_en) begin
        mask[k] = 1'b1;
        if (first == 0) begin
          first     = k;
          cyc_first = cycle_cnt;
          ph_first  = glitch_phase;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({glitch_en, busy, done, missed, pulse_cnt, cycle_cnt, glitch_phase} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs: got en=%b busy=%b done=%b missed=%b pc=%0d cc=%0d ph=%0d, want all 0",
               glitch_en, busy, done, missed, pulse_cnt, cycle_cnt, glitch_phase);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_pulse();
    logic [63:0] mask;
    int          first;
    logic [15:0] cyc;
    logic [2:0]  ph;
    write_cfg(16'd21, 4'd1, 4'd1, 16'd0, 3'd5);
    do_arm();
    trigger = 1'b1;
    tick();
    watch(30, mask, first, cyc, ph);
    checks++;
    if (mask !== 64'h0000_0000_0040_0000) begin
      failures++;
      $display("FAIL basic_mask: got %h want %h", mask, 64'h400000);
    end
    checks++;
    if (ph !== 3'd5) begin
      failures++;
      $display("FAIL basic_phase: got %0d want 5", ph);
    end
    checks++;
    if (cyc !== 16'd22) begin
      failures++;
      $display("FAIL basic_cycle_at_pulse: got %0d want 22", cyc);
    end
    checks++;
    if ({done, missed, busy, pulse_cnt} !== {1'b1, 1'b0, 1'b0, 4'd1}) begin
      failures++;
      $display("FAIL basic_end: got done=%b missed=%b busy=%b pc=%0d want 1 0 0 1",
               done, missed, busy, pulse_cnt);
    end
  endtask

  task automatic test_offset_zero_repeat();
    logic [63:0] mask;
    int          first;
    logic [15:0] cyc;
    logic [2:0]  ph;
    trigger = 1'b0;
    write_cfg(16'd0, 4'd2, 4'd3, 16'd4, 3'd3);
    do_arm();
    trigger = 1'b1;
    tick();
    watch(25, mask, first, cyc, ph);
    checks++;
    if (mask !== 64'h0000_0000_0000_6186) begin
      failures++;
      $display("FAIL repeat_mask: got %h want %h", mask, 64'h6186);
    end
    checks++;
    if ({done, missed, pulse_cnt} !== {1'b1, 1'b0, 4'd3}) begin
      failures++;
      $display("FAIL repeat_end: got done=%b missed=%b pc=%0d want 1 0 3", done, missed, pulse_cnt);
    end
  endtask

  task automatic test_early_fall();
    logic [63:0] mask;
    int          first;
    logic [15:0] cyc;
    logic [2:0]  ph;
    trigger = 1'b0;
    write_cfg(16'd10, 4'd1, 4'd2, 16'd0, 3'd1);
    do_arm();
    trigger = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) tick();
    trigger = 1'b0;
    watch(20, mask, first, cyc, ph);
    checks++;
    if (mask !== 64'd0) begin
      failures++;
      $display("FAIL early_no_glitch: got %h want 0", mask);
    end
    checks++;
    if ({done, missed, pulse_cnt} !== {1'b1, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL early_end: got done=%b missed=%b pc=%0d want 1 1 0", done, missed, pulse_cnt);
    end
  endtask

  task automatic test_trigger_before_arm();
    logic [63:0] mask;
    int          first;
    logic [15:0] cyc;
    logic [2:0]  ph;
    trigger = 1'b1;
    tick();
    tick();
    write_cfg(16'd2, 4'd1, 4'd1, 16'd0, 3'd4);
    do_arm();
    watch(10, mask, first, cyc, ph);
    checks++;
    if (mask !== 64'd0 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL prearm_hold: got mask=%h busy=%b done=%b want 0 1 0", mask, busy, done);
    end
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    watch(10, mask, first, cyc, ph);
    checks++;
    if (mask !== 64'h8) begin
      failures++;
      $display("FAIL prearm_new_edge: got %h want %h", mask, 64'h8);
    end
    checks++;
    if ({done, pulse_cnt} !== {1'b1, 4'd1}) begin
      failures++;
      $display("FAIL prearm_end: got done=%b pc=%0d want 1 1", done, pulse_cnt);
    end
  endtask

  task automatic test_abort();
    trigger = 1'b0;
    tick();
    write_cfg(16'd1, 4'd8, 4'd1, 16'd0, 3'd2);
    do_arm();
    trigger = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) tick();
    checks++;
    if (glitch_en !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_high: got %b want 1", glitch_en);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({glitch_en, busy, done, cfg_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL abort_state: got en=%b busy=%b done=%b ready=%b want 0 0 0 1",
               glitch_en, busy, done, cfg_ready);
    end
    checks++;
    if (cycle_cnt !== 16'd4) begin
      failures++;
      $display("FAIL abort_cycle_hold: got %0d want 4", cycle_cnt);
    end
  endtask

  task automatic test_lockout_rearm();
    logic [63:0] mask;
    int          first;
    logic [15:0] cyc;
    logic [2:0]  ph;
    trigger = 1'b0;
    tick();
    write_cfg(16'd5, 4'd1, 4'd1, 16'd0, 3'd6);
    do_arm();
    trigger = 1'b1;
    tick();
    write_cfg(16'd0, 4'd1, 4'd1, 16'd0, 3'd2);
    checks++;
    if (glitch_phase !== 3'd6) begin
      failures++;
      $display("FAIL lockout_phase: got %0d want 6", glitch_phase);
    end
    trigger = 1'b0;
    tick();
    checks++;
    if ({done, missed} !== 2'b11) begin
      failures++;
      $display("FAIL lockout_missed: got done=%b missed=%b want 1 1", done, missed);
    end
    cfg_valid  = 1'b1;
    cfg_offset = 16'd3;
    cfg_width  = 4'd1;
    cfg_repeat = 4'd1;
    cfg_gap    = 16'd0;
    cfg_phase  = 3'd1;
    arm        = 1'b1;
    tick();
    cfg_valid  = 1'b0;
    arm        = 1'b0;
    checks++;
    if ({done, missed, busy, glitch_phase} !== {1'b0, 1'b0, 1'b1, 3'd1}) begin
      failures++;
      $display("FAIL rearm_state: got done=%b missed=%b busy=%b ph=%0d want 0 0 1 1",
               done, missed, busy, glitch_phase);
    end
    trigger = 1'b1;
    tick();
    watch(10, mask, first, cyc, ph);
    checks++;
    if (mask !== 64'h10) begin
      failures++;
      $display("FAIL rearm_offset: got %h want %h", mask, 64'h10);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] mask;
    int          first;
    logic [15:0] cyc;
    logic [2:0]  ph;
    trigger = 1'b0;
    tick();
    write_cfg(16'd0, 4'd1, 4'd3, 16'd10, 3'd7);
    do_arm();
    trigger = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) tick();
    checks++;
    if (busy !== 1'b1 || pulse_cnt !== 4'd1) begin
      failures++;
      $display("FAIL midop_in_gap: got busy=%b pc=%0d want 1 1", busy, pulse_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({glitch_en, busy, done, missed, pulse_cnt, cycle_cnt, glitch_phase} !== 27'd0 ||
        cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL midop_reset: got en=%b busy=%b done=%b missed=%b pc=%0d cc=%0d ph=%0d ready=%b",
               glitch_en, busy, done, missed, pulse_cnt, cycle_cnt, glitch_phase, cfg_ready);
    end
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    watch(20, mask, first, cyc, ph);
    checks++;
    if (mask !== 64'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midop_no_pulse: got mask=%h busy=%b want 0 0", mask, busy);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_offset = '0;
    cfg_width  = '0;
    cfg_repeat = '0;
    cfg_gap    = '0;
    cfg_phase  = '0;
    arm        = 1'b0;
    abort      = 1'b0;
    trigger    = 1'b0;
    test_reset();
    test_basic_pulse();
    test_offset_zero_repeat();
    test_early_fall();
    test_trigger_before_arm();
    test_abort();
    test_lockout_rearm();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
